// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid register: occupancy-state enum and exception-cause type.
package pipe_pkg;

    localparam int unsigned OCC_W     = 2;
    localparam int unsigned EXC_W_DEF = 4;

    typedef logic [EXC_W_DEF-1:0] exc_code_t;

    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

    // Encoding is chosen so the state value is the entry count.
    function automatic logic [OCC_W-1:0] occ_of(input occ_state_t s);
        return OCC_W'(s);
    endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Handshake bus between an upstream stage, the skid register and the downstream stage.
interface pipe_skid_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned EXC_W  = 4
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_exc;
    logic [EXC_W-1:0]  in_exc_code;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_exc;
    logic [EXC_W-1:0]  out_exc_code;
    logic [OCC_W-1:0]  occ;

    modport slave (
        input  in_valid, in_data, in_exc, in_exc_code, out_ready,
        output in_ready, out_valid, out_data, out_exc, out_exc_code, occ
    );

    modport master (
        output in_valid, in_data, in_exc, in_exc_code, out_ready,
        input  in_ready, out_valid, out_data, out_exc, out_exc_code, occ
    );

endinterface

// File: rtl/pipe_slot.sv
// One held pipeline entry: payload, exception flag and cause, with load / clear / hold.
module pipe_slot #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned EXC_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_exc,
    input  logic [EXC_W-1:0]  d_code,
    output logic [DATA_W-1:0] q_data,
    output logic              q_exc,
    output logic [EXC_W-1:0]  q_code
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              exc_q, exc_d;
    logic [EXC_W-1:0]  code_q, code_d;

    // Clear wins so an emptied slot always presents zeros.
    always_comb begin
        data_d = data_q;
        exc_d  = exc_q;
        code_d = code_q;
        if (clr) begin
            data_d = '0;
            exc_d  = 1'b0;
            code_d = '0;
        end else if (load) begin
            data_d = d_data;
            exc_d  = d_exc;
            code_d = d_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            exc_q  <= 1'b0;
            code_q <= '0;
        end else begin
            data_q <= data_d;
            exc_q  <= exc_d;
            code_q <= code_d;
        end
    end

    assign q_data = data_q;
    assign q_exc  = exc_q;
    assign q_code = code_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register with optional two-entry skid buffer (define PIPE_SKID_EN) and exception capture.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = 128,
    parameter int unsigned       EXC_W     = 4,
    parameter logic [DATA_W-1:0] KEEP_MASK = '1
) (
    input logic            clk,
    input logic            rst,
    input logic            flush,
    pipe_skid_reg_if.slave bus
);

    occ_state_t        state_q, state_d;
    logic              out_valid, in_ready;
    logic              accept, consume;
    logic [DATA_W-1:0] cap_data;
    logic [EXC_W-1:0]  cap_code;
    logic              head_load, head_clr;
    logic [DATA_W-1:0] head_d_data, head_data;
    logic              head_d_exc, head_exc;
    logic [EXC_W-1:0]  head_d_code, head_code;

    assign out_valid = (state_q != EMPTY);
    assign accept    = bus.in_valid & in_ready & ~flush;
    assign consume   = out_valid & bus.out_ready;

    // Exception beats keep only the masked payload bits; clean beats carry no cause.
    always_comb begin
        cap_data = bus.in_data;
        cap_code = '0;
        if (bus.in_exc) begin
            cap_data = bus.in_data & KEEP_MASK;
            cap_code = bus.in_exc_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

`ifdef PIPE_SKID_EN
    logic              in_ready_q, in_ready_d;
    logic              skid_load, skid_clr, head_from_skid;
    logic [DATA_W-1:0] skid_data;
    logic              skid_exc;
    logic [EXC_W-1:0]  skid_code;

    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        head_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            head_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d   = ONE;
                    head_load = 1'b1;
                end
                ONE: if (accept && consume) begin
                    head_load = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    skid_load = 1'b1;
                end else if (consume) begin
                    state_d  = EMPTY;
                    head_clr = 1'b1;
                end
                FULL: if (consume) begin
                    state_d        = ONE;
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    // Registered ready breaks the out_ready -> in_ready path.
    always_ff @(posedge clk) begin
        if (rst) in_ready_q <= 1'b1;
        else     in_ready_q <= in_ready_d;
    end

    assign in_ready    = in_ready_q;
    assign head_d_data = head_from_skid ? skid_data : cap_data;
    assign head_d_exc  = head_from_skid ? skid_exc  : bus.in_exc;
    assign head_d_code = head_from_skid ? skid_code : cap_code;

    pipe_slot #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clr    (skid_clr),
        .d_data (cap_data),
        .d_exc  (bus.in_exc),
        .d_code (cap_code),
        .q_data (skid_data),
        .q_exc  (skid_exc),
        .q_code (skid_code)
    );
`else
    always_comb begin
        state_d   = state_q;
        head_load = 1'b0;
        head_clr  = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            head_clr = 1'b1;
        end else if (accept) begin
            state_d   = ONE;
            head_load = 1'b1;
        end else if (consume) begin
            state_d  = EMPTY;
            head_clr = 1'b1;
        end
    end

    assign in_ready    = ~out_valid | bus.out_ready;
    assign head_d_data = cap_data;
    assign head_d_exc  = bus.in_exc;
    assign head_d_code = cap_code;
`endif

    pipe_slot #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_head (
        .clk    (clk),
        .rst    (rst),
        .load   (head_load),
        .clr    (head_clr),
        .d_data (head_d_data),
        .d_exc  (head_d_exc),
        .d_code (head_d_code),
        .q_data (head_data),
        .q_exc  (head_exc),
        .q_code (head_code)
    );

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_data     = head_data;
    assign bus.out_exc      = head_exc;
    assign bus.out_exc_code = head_code;
    assign bus.occ          = occ_of(state_q);

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 128: payload width in bits (pc, npc, inst, predict_pc packed by the instantiating stage).
REQ-002 Parameter EXC_W, default 4: exception-cause width.
REQ-003 Parameter KEEP_MASK, DATA_W bits, default all-ones: payload bits retained when an exception is captured; cleared bits are forced to 0.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  discard all held entries at the next edge.
REQ-007 in_valid  input  1  upstream has a beat.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_exc  input  1  upstream beat carries an exception.
REQ-011 in_exc_code  input  EXC_W  cause of that exception.
REQ-012 out_valid  output  1  head entry is valid.
REQ-013 out_ready  input  1  downstream consumes head this cycle.
REQ-014 out_data, out_exc, out_exc_code  output  DATA_W/1/EXC_W  head entry fields.
REQ-015 occ  output  2  number of held entries (0..2).

Function
REQ-016 Accept = in_valid & in_ready & ~flush; consume = out_valid & out_ready.
REQ-017 States EMPTY (occ 0), ONE (occ 1), FULL (occ 2); FULL exists only with PIPE_SKID_EN.
REQ-018 Transitions: EMPTY->ONE on accept; ONE->FULL on accept without consume; ONE->EMPTY on consume without accept; ONE stays ONE on simultaneous accept+consume; FULL->ONE on consume (no accept possible in FULL).
REQ-019 Latency: accepted beat appears on out_* exactly one cycle after acceptance when block was EMPTY or consumed same cycle.
REQ-020 Ordering: strict FIFO; skid entry promotes to head on the consume edge.
REQ-021 Captured beat with in_exc=1 stores in_data & KEEP_MASK, out_exc=1, out_exc_code=in_exc_code; with in_exc=0, out_exc_code=0.
REQ-022 Flush has priority over accept and consume: next state EMPTY, all held payload, exc and code fields cleared to 0, same-cycle input beat dropped.
REQ-023 Consume when EMPTY is ignored; out_* when out_valid=0 hold 0.
REQ-024 Back-pressure: while out_valid & ~out_ready, head fields remain bit-stable.

Reset
REQ-025 rst has priority over flush and all handshakes; after reset: state EMPTY, occ=0, out_valid=0, out_data=0, out_exc=0, out_exc_code=0.
REQ-026 rst asserted mid-transfer discards all held entries; in_ready returns high the first cycle after rst deasserts.

Configuration
REQ-027 Macro PIPE_SKID_EN defined: two-entry skid buffer; in_ready is a registered signal equal to (occ != 2), no combinational path from out_ready.
REQ-028 PIPE_SKID_EN undefined: single entry; in_ready = ~out_valid | out_ready (combinational); occ never exceeds 1.

Structure
REQ-029 Shared package pipe_pkg holds the occupancy-state enum (EMPTY/ONE/FULL) and the exception-cause typedef sized by EXC_W default.
REQ-030 One sub-module pipe_slot (payload+exc+code register with load, clear, hold) instantiated as head and, under PIPE_SKID_EN, skid.

Verification
REQ-031 Reset then in_valid=1, in_data=0xA5, out_ready=1 -> out_valid=1, out_data=0xA5 next cycle, occ=1.
REQ-032 PIPE_SKID_EN: out_ready=0, push 0x1 and 0x2 -> occ=2, in_ready=0; out_ready=1 -> out_data 0x1 then 0x2, occ 2->1->0.
REQ-033 KEEP_MASK=0xFF00, in_exc=1, code=0x3, in_data=0x1234 -> out_data=0x1200, out_exc=1, out_exc_code=0x3.
REQ-034 FULL with flush=1 and in_valid=1 same cycle -> next cycle occ=0, out_valid=0, out_data=0, input beat lost.
REQ-035 rst and flush asserted during FULL with out_ready toggling -> all outputs 0, in_ready=1 one cycle after rst drops.
REQ-036 PIPE_SKID_EN undefined: out_valid=1, out_ready=0 -> in_ready=0; set out_ready=1 -> in_ready=1 same cycle, occ stays 1.
